// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame-format field positions and the
// parity helper used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Bit positions inside the 5-bit frame-format word.
  localparam int unsigned CONF_W        = 5;
  localparam int unsigned CONF_SIZE_MSB = 4;
  localparam int unsigned CONF_SIZE_LSB = 3;
  localparam int unsigned CONF_STOP2    = 2;
  localparam int unsigned CONF_PAR_EN   = 1;
  localparam int unsigned CONF_PAR_ODD  = 0;

  // XOR of the n low bits of data, inverted for odd parity.
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic [3:0] n,
                                       input logic       odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO with a separate level counter so full and empty never
// alias. Read data is the current head entry (no output register).
module uart_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and level next-state; pointers wrap naturally since Depth is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LvlW'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LvlW'(1);
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while the level says empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-fed frame FSM with run-time frame format.
//
// state  | meaning
// IDLE   | line high, waiting for a tick with tx_en and a queued byte
// START  | start bit (0) for one bit time
// DATA   | data bits LSB first, 5..8 of them
// PARITY | optional parity bit
// STOP   | one or two stop bits (1); may launch the next frame directly
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int OversampleRate = 16,
  parameter int FifoDepth      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         baud_en_i,
  input  logic                         tx_en_i,
  input  logic [4:0]                   tx_conf_i,
  input  logic                         tx_valid_i,
  input  logic [7:0]                   tx_data_i,
  output logic                         tx_ready_o,
  output logic                         tx_busy_o,
  output logic                         tx_done_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o,
  output logic                         uart_tx_o
);

  localparam int SampW = $clog2(OversampleRate);
  localparam logic [SampW-1:0] SampMax = SampW'(OversampleRate - 1);

  uart_state_e        state_q, state_d;
  logic [SampW-1:0]   samp_q, samp_d;
  logic [2:0]         bit_q, bit_d;
  logic               stop_q, stop_d;
  logic [7:0]         data_q, data_d;
  logic [CONF_W-1:0]  conf_q, conf_d;
  logic               tx_q, tx_d;

  logic               pop, done;
  logic               fifo_full, fifo_empty;
  logic [7:0]         fifo_rdata;
  logic               samp_last, can_pop;
  logic [2:0]         bit_inc, last_bit;
  logic [3:0]         n_bits;
  logic               par_bit;

  uart_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign samp_last = (samp_q == SampMax);
  assign can_pop   = tx_en_i && !fifo_empty;
  assign bit_inc   = bit_q + 3'd1;
  assign last_bit  = 3'd4 + {1'b0, conf_q[CONF_SIZE_MSB:CONF_SIZE_LSB]};
  assign n_bits    = 4'd5 + {2'b00, conf_q[CONF_SIZE_MSB:CONF_SIZE_LSB]};
  assign par_bit   = uart_parity(data_q, n_bits, conf_q[CONF_PAR_ODD]);

  assign tx_ready_o = !fifo_full;
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_done_o  = done;
  assign uart_tx_o  = tx_q;

  // Frame sequencing; everything advances only on baud ticks.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    conf_d  = conf_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
    if (baud_en_i) begin
      unique case (state_q)
        IDLE: begin
          if (can_pop) begin
            pop     = 1'b1;
            state_d = START;
            samp_d  = '0;
            bit_d   = '0;
            stop_d  = 1'b0;
            data_d  = fifo_rdata;
            conf_d  = tx_conf_i;
            tx_d    = 1'b0;
          end
        end
        START: begin
          if (samp_last) begin
            state_d = DATA;
            samp_d  = '0;
            bit_d   = '0;
            tx_d    = data_q[0];
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
        DATA: begin
          if (samp_last) begin
            samp_d = '0;
            if (bit_q == last_bit) begin
              if (conf_q[CONF_PAR_EN]) begin
                state_d = PARITY;
                tx_d    = par_bit;
              end else begin
                state_d = STOP;
                stop_d  = 1'b0;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_inc;
              tx_d  = data_q[bit_inc];
            end
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
        PARITY: begin
          if (samp_last) begin
            state_d = STOP;
            samp_d  = '0;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
        STOP: begin
          if (samp_last) begin
            samp_d = '0;
            if (conf_q[CONF_STOP2] && !stop_q) begin
              stop_d = 1'b1;
            end else begin
              done = 1'b1;
              if (can_pop) begin
                // Back-to-back launch: no idle bit between frames.
                pop     = 1'b1;
                state_d = START;
                bit_d   = '0;
                stop_d  = 1'b0;
                data_d  = fifo_rdata;
                conf_d  = tx_conf_i;
                tx_d    = 1'b0;
              end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
              end
            end
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // FSM, counters, shadow registers and the line register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      conf_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      conf_q  <= conf_d;
      tx_q    <= tx_d;
    end
  end

endmodule
